// File: rtl/picorv32_bus_bridge.sv
// ---------------------------------------------------------------------------
// picorv32_bus_bridge
//
// Registered bridge from the picorv32 native memory interface to the system
// Avalon-style bus. The bridge accepts one CPU request at a time. It drives
// registered bus outputs and holds them while the slave stalls. It returns a
// one-cycle mem_ready pulse. Bus error responses and waitrequest timeouts
// set a sticky error interrupt.
//
// Optional feature macro: PICORV32_BRIDGE_ERR_CAPTURE_EN
//   defined   : err_addr / err_code capture the first error since the last
//               err_clear (err_code = {timeout, bus_response})
//   undefined : err_addr / err_code are tied to 0
//
// Parameters
//   ADDR_W          bus_addr width (CPU address bits [ADDR_W-1:0] forwarded)
//   TIMEOUT_CYCLES  max stalled cycles per bus request, 0 disables timeout
//   ERR_RDATA       read data returned for errored or timed-out reads
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   mem_valid/instr/addr/
//   wdata/wstrb                CPU request (wstrb == 0 means read)
//   mem_ready, mem_rdata       CPU completion pulse and read data
//   bus_addr/read/write/
//   writedata/byteenable       registered bus request
//   bus_readdata/response/
//   waitrequest                bus slave reply
//   err_clear                  clears err_irq and capture registers
//   err_irq                    sticky error interrupt
//   err_addr, err_code         first-error capture
// ---------------------------------------------------------------------------
module picorv32_bus_bridge #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_valid,
    input  logic              mem_instr,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    input  logic [3:0]        mem_wstrb,
    output logic              mem_ready,
    output logic [31:0]       mem_rdata,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_read,
    output logic              bus_write,
    output logic [31:0]       bus_writedata,
    output logic [3:0]        bus_byteenable,
    input  logic [31:0]       bus_readdata,
    input  logic [1:0]        bus_response,
    input  logic              bus_waitrequest,
    input  logic              err_clear,
    output logic              err_irq,
    output logic [31:0]       err_addr,
    output logic [2:0]        err_code
);

    // A zero timeout still needs a one-bit counter to keep widths legal.
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
    // Counter value seen during the stalled cycle that brings it to CNT_MAX.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic              accept, complete, time_out, err_event;

    logic [ADDR_W-1:0] bus_addr_reg;
    logic              bus_read_reg;
    logic              bus_write_reg;
    logic [31:0]       bus_writedata_reg;
    logic [3:0]        bus_byteenable_reg;
    logic [31:0]       mem_rdata_reg;
    logic              mem_ready_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              err_irq_reg;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        complete   = 1'b0;
        time_out   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (mem_valid) begin
                    accept     = 1'b1;
                    state_next = BUS;
                end
            end
            BUS: begin
                // A cycle with waitrequest low always completes, so completion
                // wins over a timeout that would fall in the same cycle.
                if (!bus_waitrequest) begin
                    complete   = 1'b1;
                    state_next = DONE;
                end else if ((TIMEOUT_CYCLES != 0) && (cnt_reg == CNT_LAST)) begin
                    time_out   = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign err_event = (complete && bus_response[1]) || time_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_addr_reg       <= '0;
            bus_read_reg       <= 1'b0;
            bus_write_reg      <= 1'b0;
            bus_writedata_reg  <= '0;
            bus_byteenable_reg <= '0;
            mem_rdata_reg      <= '0;
            mem_ready_reg      <= 1'b0;
            cnt_reg            <= '0;
            err_irq_reg        <= 1'b0;
        end else begin
            mem_ready_reg <= complete || time_out;

            if (accept) begin
                bus_addr_reg       <= {mem_addr[ADDR_W-1:2], 2'b00};
                bus_writedata_reg  <= mem_wdata;
                bus_byteenable_reg <= (mem_wstrb == 4'h0) ? 4'hF : mem_wstrb;
                bus_read_reg       <= (mem_wstrb == 4'h0);
                bus_write_reg      <= (mem_wstrb != 4'h0);
                cnt_reg            <= '0;
            end

            // Saturating stall counter; the FSM leaves BUS before it could wrap.
            if ((state_reg == BUS) && bus_waitrequest && (cnt_reg != CNT_MAX)) begin
                cnt_reg <= cnt_reg + 1'b1;
            end

            if (complete || time_out) begin
                bus_read_reg  <= 1'b0;
                bus_write_reg <= 1'b0;
                // bus_read_reg is still set here, so it identifies the access
                // type. Writes leave mem_rdata untouched.
                if (bus_read_reg) begin
                    mem_rdata_reg <= (time_out || bus_response[1]) ? ERR_RDATA : bus_readdata;
                end
            end

            if (err_event) begin
                err_irq_reg <= 1'b1;
            end else if (err_clear) begin
                err_irq_reg <= 1'b0;
            end
        end
    end

    assign bus_addr       = bus_addr_reg;
    assign bus_read       = bus_read_reg;
    assign bus_write      = bus_write_reg;
    assign bus_writedata  = bus_writedata_reg;
    assign bus_byteenable = bus_byteenable_reg;
    assign mem_rdata      = mem_rdata_reg;
    assign mem_ready      = mem_ready_reg;
    assign err_irq        = err_irq_reg;

    // ------------------------------------------------------------------
    // First-error capture
    // ------------------------------------------------------------------
`ifdef PICORV32_BRIDGE_ERR_CAPTURE_EN
    logic [31:0] addr_lat_reg;
    logic [31:0] err_addr_reg;
    logic [2:0]  err_code_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_lat_reg <= '0;
            err_addr_reg <= '0;
            err_code_reg <= '0;
        end else begin
            // Full CPU address is kept, including bits above ADDR_W.
            if (accept) begin
                addr_lat_reg <= mem_addr;
            end
            // A clear coinciding with a new error leaves err_irq set, so the
            // new error becomes the captured one.
            if (err_event && (!err_irq_reg || err_clear)) begin
                err_addr_reg <= addr_lat_reg;
                err_code_reg <= {time_out, (time_out ? 2'b00 : bus_response)};
            end else if (err_clear) begin
                err_addr_reg <= '0;
                err_code_reg <= '0;
            end
        end
    end

    assign err_addr = err_addr_reg;
    assign err_code = err_code_reg;
`else
    assign err_addr = '0;
    assign err_code = '0;
`endif

    // Inputs that carry no information in some configurations.
    logic unused_inputs;
    assign unused_inputs = &{1'b0, mem_instr, mem_addr[1:0], bus_response[0]};

    generate
        if (ADDR_W < 32) begin : g_upper_addr
            logic unused_upper_addr;
            assign unused_upper_addr = &{1'b0, mem_addr[31:ADDR_W]};
        end
    endgenerate

endmodule

// File: tb/tb_picorv32_bus_bridge.sv
module tb_picorv32_bus_bridge;

    localparam int TO = 4;
    localparam logic [31:0] ERR_RD = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_valid = 1'b0;
    logic        mem_instr = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [3:0]  mem_wstrb = '0;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [31:0] bus_addr;
    logic        bus_read;
    logic        bus_write;
    logic [31:0] bus_writedata;
    logic [3:0]  bus_byteenable;
    logic [31:0] bus_readdata = '0;
    logic [1:0]  bus_response = '0;
    logic        bus_waitrequest = 1'b0;
    logic        err_clear = 1'b0;
    logic        err_irq;
    logic [31:0] err_addr;
    logic [2:0]  err_code;

    always #5 clk = ~clk;

    picorv32_bus_bridge #(
        .ADDR_W         (32),
        .TIMEOUT_CYCLES (TO),
        .ERR_RDATA      (ERR_RD)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .mem_valid       (mem_valid),
        .mem_instr       (mem_instr),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_wstrb       (mem_wstrb),
        .mem_ready       (mem_ready),
        .mem_rdata       (mem_rdata),
        .bus_addr        (bus_addr),
        .bus_read        (bus_read),
        .bus_write       (bus_write),
        .bus_writedata   (bus_writedata),
        .bus_byteenable  (bus_byteenable),
        .bus_readdata    (bus_readdata),
        .bus_response    (bus_response),
        .bus_waitrequest (bus_waitrequest),
        .err_clear       (err_clear),
        .err_irq         (err_irq),
        .err_addr        (err_addr),
        .err_code        (err_code)
    );

    // Scoreboard entry: what the CPU side must see for one access.
    typedef struct {
        logic [31:0] rdata;
        int          ready_c;
        int          req_c;
        logic        irq;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    int vectors = 0;
    int errors  = 0;

    // Observations from the most recent access.
    int          r_ready_c, r_req_first, r_req_cycles;
    logic [31:0] r_rdata, r_addr, r_wdata, r_err_addr;
    logic [3:0]  r_be;
    logic [2:0]  r_err_code;
    logic        r_is_read, r_overlap, r_unstable, r_err_irq;

    logic [31:0] last_read = '0;

    // Drives one CPU access, plays the bus slave (waits stall cycles, then
    // resp/slave_rdata), and returns as soon as mem_ready is observed.
    task automatic run_access(input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] wstrb, input int waits,
                              input logic [1:0] resp, input logic [31:0] slave_rdata);
        int stalls;
        stalls       = 0;
        r_ready_c    = -1;
        r_req_first  = -1;
        r_req_cycles = 0;
        r_overlap    = 1'b0;
        r_unstable   = 1'b0;
        r_rdata      = '0;
        mem_valid    = 1'b1;
        mem_addr     = addr;
        mem_wdata    = wdata;
        mem_wstrb    = wstrb;
        mem_instr    = (wstrb == 4'h0);
        for (int c = 1; c <= 40 && r_ready_c < 0; c++) begin
            @(posedge clk); #1;
            if (bus_read && bus_write) r_overlap = 1'b1;
            if (mem_ready) begin
                r_ready_c  = c;
                r_rdata    = mem_rdata;
                r_err_irq  = err_irq;
                r_err_addr = err_addr;
                r_err_code = err_code;
                mem_valid  = 1'b0;
            end
            if (bus_read || bus_write) begin
                if (r_req_first < 0) begin
                    r_req_first = c;
                    r_addr      = bus_addr;
                    r_be        = bus_byteenable;
                    r_wdata     = bus_writedata;
                    r_is_read   = bus_read;
                end else if (bus_addr !== r_addr || bus_byteenable !== r_be ||
                             bus_writedata !== r_wdata || bus_read !== r_is_read) begin
                    r_unstable = 1'b1;
                end
                r_req_cycles++;
                bus_waitrequest = (stalls < waits);
                if (bus_waitrequest) stalls++;
                bus_response = resp;
                bus_readdata = bus_waitrequest ? ~slave_rdata : slave_rdata;
            end else begin
                bus_waitrequest = 1'b0;
                bus_response    = 2'b00;
                bus_readdata    = '0;
            end
        end
        mem_valid = 1'b0;
        $display("txn addr=%h wstrb=%h waits=%0d resp=%b req@%0d x%0d ready@%0d rdata=%h irq=%b",
                 addr, wstrb, waits, resp, r_req_first, r_req_cycles, r_ready_c, r_rdata, r_err_irq);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({mem_ready, mem_rdata, bus_addr, bus_read, bus_write, bus_writedata,
             bus_byteenable, err_irq, err_addr, err_code} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%b rd=%b wr=%b addr=%h irq=%b, required all zero",
                     mem_ready, bus_read, bus_write, bus_addr, err_irq);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_read_zero_wait();
        sb.push_back('{rdata: 32'h1234_5678, ready_c: 2, req_c: 1, irq: 1'b0});
        run_access(32'h0000_1004, 32'h0, 4'h0, 0, 2'b00, 32'h1234_5678);
        e = sb.pop_front();
        last_read = e.rdata;
        vectors++; if (r_req_first !== 1) begin errors++; $display("FAIL rd0_req_cycle: got %0d required 1", r_req_first); end
        vectors++; if (r_is_read !== 1'b1) begin errors++; $display("FAIL rd0_is_read: got %b required 1", r_is_read); end
        vectors++; if (r_addr !== 32'h0000_1004) begin errors++; $display("FAIL rd0_addr: got %h required 00001004", r_addr); end
        vectors++; if (r_be !== 4'hF) begin errors++; $display("FAIL rd0_be: got %h required f", r_be); end
        vectors++; if (r_ready_c !== e.ready_c) begin errors++; $display("FAIL rd0_ready_cycle: got %0d required %0d", r_ready_c, e.ready_c); end
        vectors++; if (r_rdata !== e.rdata) begin errors++; $display("FAIL rd0_rdata: got %h required %h", r_rdata, e.rdata); end
        vectors++; if (r_err_irq !== e.irq) begin errors++; $display("FAIL rd0_irq: got %b required %b", r_err_irq, e.irq); end
        @(posedge clk); #1;
        vectors++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL rd0_ready_pulse: got %b required 0", mem_ready); end
    endtask

    task automatic test_write_waits();
        sb.push_back('{rdata: last_read, ready_c: 5, req_c: 4, irq: 1'b0});
        run_access(32'h0000_2002, 32'hA5A5_A5A5, 4'b1100, 3, 2'b00, 32'h0);
        e = sb.pop_front();
        vectors++; if (r_is_read !== 1'b0) begin errors++; $display("FAIL wr3_is_write: got read=%b required 0", r_is_read); end
        vectors++; if (r_addr !== 32'h0000_2000) begin errors++; $display("FAIL wr3_addr: got %h required 00002000", r_addr); end
        vectors++; if (r_be !== 4'b1100) begin errors++; $display("FAIL wr3_be: got %b required 1100", r_be); end
        vectors++; if (r_wdata !== 32'hA5A5_A5A5) begin errors++; $display("FAIL wr3_wdata: got %h required a5a5a5a5", r_wdata); end
        vectors++; if (r_req_cycles !== e.req_c) begin errors++; $display("FAIL wr3_hold: got %0d cycles required %0d", r_req_cycles, e.req_c); end
        vectors++; if (r_unstable !== 1'b0) begin errors++; $display("FAIL wr3_stable: got unstable=%b required 0", r_unstable); end
        vectors++; if (r_ready_c !== e.ready_c) begin errors++; $display("FAIL wr3_ready_cycle: got %0d required %0d", r_ready_c, e.ready_c); end
        vectors++; if (r_rdata !== e.rdata) begin errors++; $display("FAIL wr3_rdata_hold: got %h required %h", r_rdata, e.rdata); end
        vectors++; if (r_err_irq !== e.irq) begin errors++; $display("FAIL wr3_irq: got %b required %b", r_err_irq, e.irq); end
        @(posedge clk); #1;
        vectors++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL wr3_ready_once: got %b required 0", mem_ready); end
    endtask

    task automatic test_reserved_resp();
        sb.push_back('{rdata: 32'h0F0F_1234, ready_c: 2, req_c: 1, irq: 1'b0});
        run_access(32'h0000_0108, 32'h0, 4'h0, 0, 2'b01, 32'h0F0F_1234);
        e = sb.pop_front();
        last_read = e.rdata;
        vectors++; if (r_rdata !== e.rdata) begin errors++; $display("FAIL resp01_rdata: got %h required %h", r_rdata, e.rdata); end
        vectors++; if (r_err_irq !== e.irq) begin errors++; $display("FAIL resp01_irq: got %b required %b", r_err_irq, e.irq); end
        @(posedge clk); #1;
    endtask

    task automatic test_error_resp();
        sb.push_back('{rdata: ERR_RD, ready_c: 2, req_c: 1, irq: 1'b1});
        run_access(32'h0000_1004, 32'h0, 4'h0, 0, 2'b11, 32'h1111_2222);
        e = sb.pop_front();
        last_read = e.rdata;
        vectors++; if (r_rdata !== e.rdata) begin errors++; $display("FAIL resp11_rdata: got %h required %h", r_rdata, e.rdata); end
        vectors++; if (r_err_irq !== e.irq) begin errors++; $display("FAIL resp11_irq: got %b required %b", r_err_irq, e.irq); end
`ifdef PICORV32_BRIDGE_ERR_CAPTURE_EN
        vectors++; if (r_err_code !== 3'b011) begin errors++; $display("FAIL resp11_code: got %b required 011", r_err_code); end
        vectors++; if (r_err_addr !== 32'h0000_1004) begin errors++; $display("FAIL resp11_addr: got %h required 00001004", r_err_addr); end
`else
        vectors++; if (r_err_code !== 3'b000) begin errors++; $display("FAIL resp11_code: got %b required 000", r_err_code); end
        vectors++; if (r_err_addr !== 32'h0) begin errors++; $display("FAIL resp11_addr: got %h required 00000000", r_err_addr); end
`endif
        @(posedge clk); #1;
        // A second error (write, SLAVEERROR) must not overwrite the capture.
        sb.push_back('{rdata: last_read, ready_c: 2, req_c: 1, irq: 1'b1});
        run_access(32'h0000_3000, 32'h5555_0000, 4'b0011, 0, 2'b10, 32'h0);
        e = sb.pop_front();
        vectors++; if (r_rdata !== e.rdata) begin errors++; $display("FAIL resp10w_rdata_hold: got %h required %h", r_rdata, e.rdata); end
        vectors++; if (r_err_irq !== e.irq) begin errors++; $display("FAIL resp10w_irq: got %b required %b", r_err_irq, e.irq); end
`ifdef PICORV32_BRIDGE_ERR_CAPTURE_EN
        vectors++; if (r_err_addr !== 32'h0000_1004) begin errors++; $display("FAIL resp10w_addr_kept: got %h required 00001004", r_err_addr); end
`endif
        @(posedge clk); #1;
        err_clear = 1'b1;
        @(posedge clk); #1;
        err_clear = 1'b0;
        vectors++; if (err_irq !== 1'b0) begin errors++; $display("FAIL clear_irq: got %b required 0", err_irq); end
        vectors++; if ({err_addr, err_code} !== '0) begin errors++; $display("FAIL clear_capture: got addr=%h code=%b required 0", err_addr, err_code); end
    endtask

    task automatic test_timeout();
        // One stall short of the limit: completes normally.
        sb.push_back('{rdata: 32'h3333_4444, ready_c: TO + 1, req_c: TO, irq: 1'b0});
        run_access(32'h0000_4000, 32'h0, 4'h0, TO - 1, 2'b00, 32'h3333_4444);
        e = sb.pop_front();
        last_read = e.rdata;
        vectors++; if (r_rdata !== e.rdata) begin errors++; $display("FAIL to_edge_rdata: got %h required %h", r_rdata, e.rdata); end
        vectors++; if (r_ready_c !== e.ready_c) begin errors++; $display("FAIL to_edge_ready_cycle: got %0d required %0d", r_ready_c, e.ready_c); end
        vectors++; if (r_err_irq !== e.irq) begin errors++; $display("FAIL to_edge_irq: got %b required %b", r_err_irq, e.irq); end
        @(posedge clk); #1;
        // Stuck waitrequest: drops after TO stalled cycles.
        sb.push_back('{rdata: ERR_RD, ready_c: TO + 1, req_c: TO, irq: 1'b1});
        run_access(32'h0000_4008, 32'h0, 4'h0, 100, 2'b00, 32'h5555_6666);
        e = sb.pop_front();
        last_read = e.rdata;
        vectors++; if (r_req_cycles !== e.req_c) begin errors++; $display("FAIL to_req_cycles: got %0d required %0d", r_req_cycles, e.req_c); end
        vectors++; if (r_ready_c !== e.ready_c) begin errors++; $display("FAIL to_ready_cycle: got %0d required %0d", r_ready_c, e.ready_c); end
        vectors++; if (r_rdata !== e.rdata) begin errors++; $display("FAIL to_rdata: got %h required %h", r_rdata, e.rdata); end
        vectors++; if (r_err_irq !== e.irq) begin errors++; $display("FAIL to_irq: got %b required %b", r_err_irq, e.irq); end
`ifdef PICORV32_BRIDGE_ERR_CAPTURE_EN
        vectors++; if (r_err_code !== 3'b100) begin errors++; $display("FAIL to_code: got %b required 100", r_err_code); end
        vectors++; if (r_err_addr !== 32'h0000_4008) begin errors++; $display("FAIL to_addr: got %h required 00004008", r_err_addr); end
`endif
        @(posedge clk); #1;
        vectors++; if (bus_read !== 1'b0) begin errors++; $display("FAIL to_read_dropped: got %b required 0", bus_read); end
        err_clear = 1'b1;
        @(posedge clk); #1;
        err_clear = 1'b0;
        vectors++; if (err_irq !== 1'b0) begin errors++; $display("FAIL to_clear_irq: got %b required 0", err_irq); end
    endtask

    task automatic test_back_to_back();
        sb.push_back('{rdata: 32'hCAFE_0001, ready_c: 2, req_c: 1, irq: 1'b0});
        run_access(32'h0000_5000, 32'h0, 4'h0, 0, 2'b00, 32'hCAFE_0001);
        e = sb.pop_front();
        last_read = e.rdata;
        vectors++; if (r_rdata !== e.rdata) begin errors++; $display("FAIL b2b_rd_rdata: got %h required %h", r_rdata, e.rdata); end
        vectors++; if (r_overlap !== 1'b0) begin errors++; $display("FAIL b2b_rd_overlap: got %b required 0", r_overlap); end
        // New request raised in the mem_ready cycle: accepted the next cycle.
        sb.push_back('{rdata: last_read, ready_c: 3, req_c: 1, irq: 1'b0});
        run_access(32'h0000_5004, 32'h0BAD_CAFE, 4'hF, 0, 2'b00, 32'h0);
        e = sb.pop_front();
        vectors++; if (r_req_first !== 2) begin errors++; $display("FAIL b2b_wr_req_cycle: got %0d required 2", r_req_first); end
        vectors++; if (r_ready_c !== e.ready_c) begin errors++; $display("FAIL b2b_wr_ready_cycle: got %0d required %0d", r_ready_c, e.ready_c); end
        vectors++; if (r_overlap !== 1'b0) begin errors++; $display("FAIL b2b_wr_overlap: got %b required 0", r_overlap); end
        vectors++; if (r_addr !== 32'h0000_5004) begin errors++; $display("FAIL b2b_wr_addr: got %h required 00005004", r_addr); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_bus();
        mem_valid = 1'b1;
        mem_addr  = 32'h0000_6000;
        mem_wstrb = 4'h0;
        bus_waitrequest = 1'b1;
        @(posedge clk); #1;
        vectors++; if (bus_read !== 1'b1) begin errors++; $display("FAIL rstmid_req: got %b required 1", bus_read); end
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({mem_ready, mem_rdata, bus_addr, bus_read, bus_write, bus_writedata,
             bus_byteenable, err_irq, err_addr, err_code} !== '0) begin
            errors++;
            $display("FAIL rstmid_outputs: got rd=%b addr=%h rdata=%h be=%h, required all zero",
                     bus_read, bus_addr, mem_rdata, bus_byteenable);
        end
        mem_valid = 1'b0;
        bus_waitrequest = 1'b0;
        last_read = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        sb.push_back('{rdata: 32'h7777_8888, ready_c: 2, req_c: 1, irq: 1'b0});
        run_access(32'h0000_1004, 32'h0, 4'h0, 0, 2'b00, 32'h7777_8888);
        e = sb.pop_front();
        vectors++; if (r_req_first !== 1) begin errors++; $display("FAIL rstmid_after_req: got %0d required 1", r_req_first); end
        vectors++; if (r_ready_c !== e.ready_c) begin errors++; $display("FAIL rstmid_after_ready: got %0d required %0d", r_ready_c, e.ready_c); end
        vectors++; if (r_rdata !== e.rdata) begin errors++; $display("FAIL rstmid_after_rdata: got %h required %h", r_rdata, e.rdata); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_read_zero_wait();
        test_write_waits();
        test_reserved_resp();
        test_error_resp();
        test_timeout();
        test_back_to_back();
        test_reset_mid_bus();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
